pll_lock_supervisor: RTL and testbench

//  Consumer side of the PLL lock output. Samples the asynchronous PLL
//  'locked' flag and qualifies it (stable-hold, then reset stretch).

---
 rtl/pll_lock_supervisor_pkg.sv | 13 +
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 132 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// rtl/pll_lock_supervisor_pkg.sv - shared state encodings for the PLL lock supervisor
package pll_lock_supervisor_pkg;

    localparam int PLLSUP_STATE_W = 3;

    typedef enum logic [PLLSUP_STATE_W-1:0] {
        PLLSUP_WAIT_LOCK = 3'd0,
        PLLSUP_STABILIZE = 3'd1,
        PLLSUP_STRETCH   = 3'd2,
        PLLSUP_RUN       = 3'd3
    } pllsup_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - multi-flop synchronizer for a single asynchronous level
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_sr;

    // Shift the async level through STAGES flops; only the last one is used downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr <= '0;
        end else begin
            sync_sr <= {sync_sr[STAGES-2:0], d};
        end
    end

    assign q = sync_sr[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - qualifies PLL lock, drives system reset, counts lock losses
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int LOCK_HOLD     = 1024,
    parameter int RESET_STRETCH = 16,
    parameter int TIMEOUT       = 65535,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             locked,
    input  logic             sw_reset_req,
    input  logic             clr_count,
    output logic             sys_resetn,
    output logic             pll_ok,
    output logic             lost_pulse,
    output logic [CNT_W-1:0] loss_count,
    output logic             lock_timeout,
    output logic [2:0]       state_o
);

    localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
    localparam int STR_W  = $clog2(RESET_STRETCH + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    pllsup_state_e state;
    pllsup_state_e next_state;
    logic          locked_s;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STR_W-1:0]  str_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic          loss_evt;
    logic          to_inc;

    sync_2ff #(
        .STAGES (SYNC_STAGES)
    ) u_locked_sync (
        .clk   (clk),
        .rst_n (resetn),
        .d     (locked),
        .q     (locked_s)
    );

    // A loss is only a loss once we have been released into RUN
    assign loss_evt = (state == PLLSUP_RUN) && !locked_s;

    // The timeout window covers every non-RUN cycle; the counter parks at TIMEOUT
    assign to_inc = (state != PLLSUP_RUN) && (to_cnt != TO_W'(TIMEOUT));

    // Next-state decode; any unused encoding falls back to WAIT_LOCK
    always_comb begin
        next_state = PLLSUP_WAIT_LOCK;
        if (!sw_reset_req) begin
            case (state)
                PLLSUP_WAIT_LOCK: next_state = locked_s ? PLLSUP_STABILIZE : PLLSUP_WAIT_LOCK;
                PLLSUP_STABILIZE: begin
                    if (!locked_s)
                        next_state = PLLSUP_WAIT_LOCK;
                    else if (hold_cnt == HOLD_W'(LOCK_HOLD))
                        next_state = PLLSUP_STRETCH;
                    else
                        next_state = PLLSUP_STABILIZE;
                end
                PLLSUP_STRETCH: begin
                    if (!locked_s)
                        next_state = PLLSUP_WAIT_LOCK;
                    else if (str_cnt == STR_W'(RESET_STRETCH))
                        next_state = PLLSUP_RUN;
                    else
                        next_state = PLLSUP_STRETCH;
                end
                PLLSUP_RUN:       next_state = locked_s ? PLLSUP_RUN : PLLSUP_WAIT_LOCK;
                default:          next_state = PLLSUP_WAIT_LOCK;
            endcase
        end
    end

    // State, qualification counters and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= PLLSUP_WAIT_LOCK;
            hold_cnt     <= '0;
            str_cnt      <= '0;
            to_cnt       <= '0;
            sys_resetn   <= 1'b0;
            pll_ok       <= 1'b0;
            lost_pulse   <= 1'b0;
            loss_count   <= '0;
            lock_timeout <= 1'b0;
        end else begin
            state <= next_state;

            // Registering next_state==RUN keeps the reset release glitch-free
            sys_resetn <= (next_state == PLLSUP_RUN);
            pll_ok     <= (next_state == PLLSUP_RUN);

            // Counters restart from 1 on entry and clear whenever their state is left
            if (next_state == PLLSUP_STABILIZE)
                hold_cnt <= (state == PLLSUP_STABILIZE) ? hold_cnt + HOLD_W'(1) : HOLD_W'(1);
            else
                hold_cnt <= '0;

            if (next_state == PLLSUP_STRETCH)
                str_cnt <= (state == PLLSUP_STRETCH) ? str_cnt + STR_W'(1) : STR_W'(1);
            else
                str_cnt <= '0;

            if (sw_reset_req || next_state == PLLSUP_RUN)
                to_cnt <= '0;
            else if (to_inc)
                to_cnt <= to_cnt + TO_W'(1);

            // Sticky: the FSM keeps retrying but software must see the slow start
            if (!sw_reset_req && next_state != PLLSUP_RUN && to_inc &&
                to_cnt == TO_W'(TIMEOUT - 1))
                lock_timeout <= 1'b1;

            // A loss coinciding with sw_reset_req is still reported
            lost_pulse <= loss_evt;

            if (clr_count)
                loss_count <= loss_evt ? CNT_W'(1) : '0;
            else if (loss_evt && loss_count != {CNT_W{1'b1}})
                loss_count <= loss_count + CNT_W'(1);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    logic       clk;
    logic       resetn;
    logic       locked;
    logic       sw_reset_req;
    logic       clr_count;
    logic       sys_resetn;
    logic       pll_ok;
    logic       lost_pulse;
    logic [3:0] loss_count;
    logic       lock_timeout;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES   (2),
        .LOCK_HOLD     (8),
        .RESET_STRETCH (4),
        .TIMEOUT       (32),
        .CNT_W         (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .locked       (locked),
        .sw_reset_req (sw_reset_req),
        .clr_count    (clr_count),
        .sys_resetn   (sys_resetn),
        .pll_ok       (pll_ok),
        .lost_pulse   (lost_pulse),
        .loss_count   (loss_count),
        .lock_timeout (lock_timeout),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each step lets exactly one rising edge pass; inputs change and outputs are read at negedge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        locked = 1'b0;
        step(2);
        resetn = 1'b1;
    endtask

    initial begin
        resetn       = 1'b0;
        locked       = 1'b0;
        sw_reset_req = 1'b0;
        clr_count    = 1'b0;
        #1;
        chk("rst_sys_resetn", {31'd0, sys_resetn}, 32'd0);
        chk("rst_pll_ok", {31'd0, pll_ok}, 32'd0);
        chk("rst_state", {29'd0, state_o}, 32'd0);
        chk("rst_loss_count", {28'd0, loss_count}, 32'd0);
        chk("rst_timeout", {31'd0, lock_timeout}, 32'd0);
        step(2);

        // 1 clean start: release on edge 14 after the first sampling edge
        resetn = 1'b1;
        locked = 1'b1;
        step(14);
        chk("t1_not_early", {31'd0, sys_resetn}, 32'd0);
        chk("t1_in_stretch", {29'd0, state_o}, 32'd2);
        step(1);
        chk("t1_release", {31'd0, sys_resetn}, 32'd1);
        chk("t1_pll_ok", {31'd0, pll_ok}, 32'd1);
        chk("t1_state_run", {29'd0, state_o}, 32'd3);
        chk("t1_loss_count", {28'd0, loss_count}, 32'd0);
        chk("t1_timeout", {31'd0, lock_timeout}, 32'd0);

        // 3 loss in RUN: reset drops on the third edge after the drop
        locked = 1'b0;
        step(2);
        chk("t3_still_high", {31'd0, sys_resetn}, 32'd1);
        step(1);
        chk("t3_sys_low", {31'd0, sys_resetn}, 32'd0);
        chk("t3_pulse", {31'd0, lost_pulse}, 32'd1);
        chk("t3_count", {28'd0, loss_count}, 32'd1);
        chk("t3_state", {29'd0, state_o}, 32'd0);
        locked = 1'b1;
        step(1);
        chk("t3_pulse_1cyc", {31'd0, lost_pulse}, 32'd0);
        step(13);
        chk("t3_relock_early", {31'd0, sys_resetn}, 32'd0);
        step(1);
        chk("t3_relock", {31'd0, sys_resetn}, 32'd1);

        // 2 chatter during STABILIZE: no loss, release 14 edges after final rise
        do_reset();
        locked = 1'b1;
        step(5);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(14);
        chk("t2_not_early", {31'd0, sys_resetn}, 32'd0);
        step(1);
        chk("t2_release", {31'd0, sys_resetn}, 32'd1);
        chk("t2_no_loss", {28'd0, loss_count}, 32'd0);

        // 4 saturation after 17 losses, then clear colliding with a loss
        for (int i = 0; i < 17; i++) begin
            locked = 1'b0;
            step(3);
            locked = 1'b1;
            step(15);
        end
        chk("t4_run_again", {31'd0, pll_ok}, 32'd1);
        chk("t4_saturated", {28'd0, loss_count}, 32'd15);
        locked = 1'b0;
        step(2);
        clr_count = 1'b1;
        step(1);
        clr_count = 1'b0;
        chk("t4_clr_with_loss", {28'd0, loss_count}, 32'd1);
        chk("t4_clr_pulse", {31'd0, lost_pulse}, 32'd1);
        clr_count = 1'b1;
        step(1);
        clr_count = 1'b0;
        chk("t4_clr_alone", {28'd0, loss_count}, 32'd0);

        // 5 timeout with locked stuck low, sticky across a later lock
        do_reset();
        step(31);
        chk("t5_before_timeout", {31'd0, lock_timeout}, 32'd0);
        step(1);
        chk("t5_timeout", {31'd0, lock_timeout}, 32'd1);
        locked = 1'b1;
        step(15);
        chk("t5_run_after", {31'd0, pll_ok}, 32'd1);
        chk("t5_sticky", {31'd0, lock_timeout}, 32'd1);

        // 6 sw_reset_req in RUN, then async reset mid-STRETCH
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        chk("t6_sw_sys_low", {31'd0, sys_resetn}, 32'd0);
        chk("t6_sw_state", {29'd0, state_o}, 32'd0);
        chk("t6_sw_no_pulse", {31'd0, lost_pulse}, 32'd0);
        chk("t6_sw_no_count", {28'd0, loss_count}, 32'd0);
        step(10);
        chk("t6_in_stretch", {29'd0, state_o}, 32'd2);
        resetn = 1'b0;
        #1;
        chk("t6_async_state", {29'd0, state_o}, 32'd0);
        chk("t6_async_timeout", {31'd0, lock_timeout}, 32'd0);
        chk("t6_async_sys", {31'd0, sys_resetn}, 32'd0);
        chk("t6_async_ok", {31'd0, pll_ok}, 32'd0);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
